// File: rtl/pc_sequencer_pkg.sv
// Purpose: shared types and constants for the fetch-side PC sequencer.
// Contents: FSM state enum, alignment-shift helper and its default value.
// Used by: pc_sequencer, pc_next_mux.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_TRAP  = 2'd3
   } pc_state_e;

   // log2 of a power-of-two instruction size; used to clear the low
   // address bits of redirect targets.
   function automatic int unsigned log2_bytes(input int unsigned bytes);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((32'd1 << i) == bytes) r = i;
      end
      return r;
   endfunction

   localparam int unsigned INSTR_BYTES_DEF = 4;
   localparam int unsigned ALIGN_SHIFT     = log2_bytes(INSTR_BYTES_DEF);

endpackage

// File: rtl/pc_sequencer_if.sv
// Purpose: groups the redirect, stall and instruction-memory fetch signals.
// Ports: i_* are driven by execute/trap/decode/imem, o_* by the sequencer.
// Modports: slave = sequencer view, master = surrounding logic view.
interface pc_sequencer_if #(
   parameter int DATA_WIDTH_P = 32
);
   logic                    i_stall;
   logic                    i_branch_valid;
   logic [DATA_WIDTH_P-1:0] i_branch_target;
   logic                    i_trap_valid;
   logic                    i_imem_ready;
   logic                    o_imem_req_valid;
   logic [DATA_WIDTH_P-1:0] o_imem_addr;
   logic                    o_pc_valid;
   logic [DATA_WIDTH_P-1:0] o_pc;
   logic                    o_flush;

   modport slave (
      input  i_stall, i_branch_valid, i_branch_target, i_trap_valid, i_imem_ready,
      output o_imem_req_valid, o_imem_addr, o_pc_valid, o_pc, o_flush
   );

   modport master (
      output i_stall, i_branch_valid, i_branch_target, i_trap_valid, i_imem_ready,
      input  o_imem_req_valid, o_imem_addr, o_pc_valid, o_pc, o_flush
   );
endinterface

// File: rtl/pc_sequencer_next_mux.sv
// Purpose: priority select of the next fetch address (trap, branch, increment, hold).
// Latency: purely combinational.
// Backpressure: none here; the caller supplies the handshake indication.
module pc_next_mux
   import pc_seq_pkg::*;
#(
   parameter int                       DATA_WIDTH_P  = 32,
   parameter logic [DATA_WIDTH_P-1:0]  TRAP_VECTOR_P = 32'h0000_0100,
   parameter int                       INSTR_BYTES_P = 4
) (
   input  logic                    trap_vld,
   input  logic                    branch_vld,
   input  logic [DATA_WIDTH_P-1:0] branch_target,
   input  logic                    hs,
   input  logic [DATA_WIDTH_P-1:0] cur_addr,
   input  logic                    pend_vld,
   input  logic                    pend_trap,
   input  logic [DATA_WIDTH_P-1:0] pend_target,
   output logic [DATA_WIDTH_P-1:0] nxt_addr,
   output logic                    redirect,
   output logic                    redirect_trap
);
   localparam int unsigned             SHIFT      = log2_bytes(INSTR_BYTES_P);
   localparam logic [DATA_WIDTH_P-1:0] ALIGN_MASK = {DATA_WIDTH_P{1'b1}} << SHIFT;
   localparam logic [DATA_WIDTH_P-1:0] INC        = DATA_WIDTH_P'(INSTR_BYTES_P);

   // A pending redirect only exists while a request is stuck in WAIT.
   // New trap beats everything; a pending trap beats a new branch;
   // a new branch replaces an older pending branch.
   always_comb begin
      nxt_addr      = cur_addr;
      redirect      = 1'b0;
      redirect_trap = 1'b0;
      if (trap_vld || (pend_vld && pend_trap)) begin
         nxt_addr      = TRAP_VECTOR_P;
         redirect      = 1'b1;
         redirect_trap = 1'b1;
      end else if (branch_vld) begin
         nxt_addr = branch_target & ALIGN_MASK;
         redirect = 1'b1;
      end else if (pend_vld) begin
         nxt_addr = pend_target;
         redirect = 1'b1;
      end else if (hs) begin
         // Natural wrap at the top of the address space.
         nxt_addr = cur_addr + INC;
      end
   end
endmodule

// File: rtl/pc_sequencer.sv
// Purpose: owns the PC; issues valid/ready fetches and reports accepted/squashed fetches.
// Latency: o_pc/o_pc_valid/o_flush one cycle after the handshake; BOOT and TRAP each cost one cycle.
// Backpressure: i_stall gates new requests in ISSUE; once presented, a request is held until imem ready.
module pc_sequencer #(
   parameter int                       DATA_WIDTH_P   = 32,
   parameter logic [DATA_WIDTH_P-1:0]  RESET_VECTOR_P = '0,
   parameter logic [DATA_WIDTH_P-1:0]  TRAP_VECTOR_P  = 32'h0000_0100,
   parameter int                       INSTR_BYTES_P  = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   pc_sequencer_if.slave   bus
);
   import pc_seq_pkg::*;

   pc_state_e               state_q, state_d;
   logic [DATA_WIDTH_P-1:0] addr_q, addr_d;
   logic [DATA_WIDTH_P-1:0] pc_q, pc_d;
   logic                    pc_vld_q, pc_vld_d;
   logic                    flush_q, flush_d;
   logic                    pend_vld_q, pend_vld_d;
   logic                    pend_trap_q, pend_trap_d;
   logic [DATA_WIDTH_P-1:0] pend_tgt_q, pend_tgt_d;

   logic                    req_vld;
   logic                    hs;
   logic [DATA_WIDTH_P-1:0] sel_addr;
   logic                    sel_redirect;
   logic                    sel_trap;

   // Only output not taken from a register: stall must block a request in the same cycle.
   assign req_vld = (state_q == ST_ISSUE) ? !bus.i_stall : (state_q == ST_WAIT);
   assign hs      = req_vld && bus.i_imem_ready;

   pc_next_mux #(
      .DATA_WIDTH_P  (DATA_WIDTH_P),
      .TRAP_VECTOR_P (TRAP_VECTOR_P),
      .INSTR_BYTES_P (INSTR_BYTES_P)
   ) u_next_mux (
      .trap_vld      (bus.i_trap_valid),
      .branch_vld    (bus.i_branch_valid),
      .branch_target (bus.i_branch_target),
      .hs            (hs),
      .cur_addr      (addr_q),
      .pend_vld      (pend_vld_q),
      .pend_trap     (pend_trap_q),
      .pend_target   (pend_tgt_q),
      .nxt_addr      (sel_addr),
      .redirect      (sel_redirect),
      .redirect_trap (sel_trap)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      pc_d        = pc_q;
      pc_vld_d    = 1'b0;
      flush_d     = 1'b0;
      pend_vld_d  = pend_vld_q;
      pend_trap_d = pend_trap_q;
      pend_tgt_d  = pend_tgt_q;
      case (state_q)
         ST_ISSUE: begin
            if (sel_redirect) begin
               // A fetch accepted in the same cycle as a redirect is squashed.
               addr_d  = sel_addr;
               flush_d = hs;
               state_d = sel_trap ? ST_TRAP : ST_ISSUE;
            end else if (hs) begin
               pc_d     = addr_q;
               pc_vld_d = 1'b1;
               addr_d   = sel_addr;
            end else if (req_vld) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.i_imem_ready) begin
               if (sel_redirect) begin
                  addr_d  = sel_addr;
                  flush_d = 1'b1;
                  state_d = sel_trap ? ST_TRAP : ST_ISSUE;
               end else begin
                  pc_d     = addr_q;
                  pc_vld_d = 1'b1;
                  addr_d   = sel_addr;
                  state_d  = ST_ISSUE;
               end
               pend_vld_d  = 1'b0;
               pend_trap_d = 1'b0;
               pend_tgt_d  = '0;
            end else if (sel_redirect) begin
               // Address on the bus is committed; park the redirect until the handshake completes.
               pend_vld_d  = 1'b1;
               pend_trap_d = sel_trap;
               pend_tgt_d  = sel_addr;
            end
         end
         ST_BOOT, ST_TRAP: begin
            state_d = ST_ISSUE;
            if (sel_redirect) begin
               addr_d  = sel_addr;
               state_d = sel_trap ? ST_TRAP : ST_ISSUE;
            end
         end
         default: state_d = ST_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_BOOT;
         addr_q      <= RESET_VECTOR_P;
         pc_q        <= '0;
         pc_vld_q    <= 1'b0;
         flush_q     <= 1'b0;
         pend_vld_q  <= 1'b0;
         pend_trap_q <= 1'b0;
         pend_tgt_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         pc_q        <= pc_d;
         pc_vld_q    <= pc_vld_d;
         flush_q     <= flush_d;
         pend_vld_q  <= pend_vld_d;
         pend_trap_q <= pend_trap_d;
         pend_tgt_q  <= pend_tgt_d;
      end
   end

   assign bus.o_imem_req_valid = req_vld;
   assign bus.o_imem_addr      = addr_q;
   assign bus.o_pc             = pc_q;
   assign bus.o_pc_valid       = pc_vld_q;
   assign bus.o_flush          = flush_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Purpose: directed self-checking bench for pc_sequencer (default reset vector and a wrap-around reset vector).
// Stimulus: linear sequence of hand-computed steps; inputs change 2ns after the rising edge.
// Outputs are compared with immediate assertions away from the clock edge.
module tb_pc_sequencer;
   logic clk;
   logic reset_n;
   logic rst_b_n;
   int   checks;
   int   errors;

   pc_sequencer_if #(.DATA_WIDTH_P(32)) a ();
   pc_sequencer_if #(.DATA_WIDTH_P(32)) b ();

   pc_sequencer #(
      .DATA_WIDTH_P   (32),
      .RESET_VECTOR_P (32'h0000_0000),
      .TRAP_VECTOR_P  (32'h0000_0100),
      .INSTR_BYTES_P  (4)
   ) dut_a (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (a)
   );

   pc_sequencer #(
      .DATA_WIDTH_P   (32),
      .RESET_VECTOR_P (32'hFFFF_FFF8),
      .TRAP_VECTOR_P  (32'h0000_0100),
      .INSTR_BYTES_P  (4)
   ) dut_b (
      .clk     (clk),
      .reset_n (rst_b_n),
      .bus     (b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      reset_n = 1'b0;
      rst_b_n = 1'b0;
      a.i_stall = 1'b0; a.i_branch_valid = 1'b0; a.i_branch_target = '0;
      a.i_trap_valid = 1'b0; a.i_imem_ready = 1'b1;
      b.i_stall = 1'b0; b.i_branch_valid = 1'b0; b.i_branch_target = '0;
      b.i_trap_valid = 1'b0; b.i_imem_ready = 1'b1;

      // Reset state
      #12;
      check("rst_req",    32'(a.o_imem_req_valid), 32'h0);
      check("rst_addr",   a.o_imem_addr,           32'h0);
      check("rst_pc",     a.o_pc,                  32'h0);
      check("rst_pcvld",  32'(a.o_pc_valid),       32'h0);
      check("rst_flush",  32'(a.o_flush),          32'h0);

      // 1. Boot then sequential fetches
      @(negedge clk); reset_n = 1'b1;
      #1 check("boot_req", 32'(a.o_imem_req_valid), 32'h0);
      tick();
      check("iss_req0",  32'(a.o_imem_req_valid), 32'h1);
      check("iss_addr0", a.o_imem_addr,           32'h0);
      check("iss_pcvld0", 32'(a.o_pc_valid),      32'h0);
      tick();
      check("f0_pcvld", 32'(a.o_pc_valid), 32'h1);
      check("f0_pc",    a.o_pc,            32'h0);
      check("f0_addr",  a.o_imem_addr,     32'h4);
      tick();
      check("f1_pcvld", 32'(a.o_pc_valid), 32'h1);
      check("f1_pc",    a.o_pc,            32'h4);
      tick();
      check("f2_pcvld", 32'(a.o_pc_valid), 32'h1);
      check("f2_pc",    a.o_pc,            32'h8);
      check("f2_addr",  a.o_imem_addr,     32'hC);

      // 2. Stall for three cycles
      a.i_stall = 1'b1;
      #1 check("stall_req1", 32'(a.o_imem_req_valid), 32'h0);
      tick();
      check("stall_pcvld", 32'(a.o_pc_valid),       32'h0);
      check("stall_req2",  32'(a.o_imem_req_valid), 32'h0);
      tick();
      check("stall_req3",  32'(a.o_imem_req_valid), 32'h0);
      check("stall_addr",  a.o_imem_addr,           32'hC);
      tick();
      a.i_stall = 1'b0;
      #1 check("resume_req", 32'(a.o_imem_req_valid), 32'h1);
      check("resume_addr", a.o_imem_addr, 32'hC);
      tick();
      check("fC_pcvld", 32'(a.o_pc_valid), 32'h1);
      check("fC_pc",    a.o_pc,            32'hC);
      check("fC_addr",  a.o_imem_addr,     32'h10);

      // 3. Backpressure at 0x10, branch to 0x203 in the second low cycle
      a.i_imem_ready = 1'b0;
      tick();
      check("wait_pcvld", 32'(a.o_pc_valid), 32'h0);
      a.i_branch_valid = 1'b1; a.i_branch_target = 32'h0000_0203;
      #1 check("wait_req", 32'(a.o_imem_req_valid), 32'h1);
      tick();
      a.i_branch_valid = 1'b0; a.i_branch_target = '0;
      check("wait_addr1", a.o_imem_addr,     32'h10);
      check("wait_flush", 32'(a.o_flush),    32'h0);
      tick();
      check("wait_addr2", a.o_imem_addr,     32'h10);
      tick();
      check("wait_addr3", a.o_imem_addr,     32'h10);
      check("wait_req3",  32'(a.o_imem_req_valid), 32'h1);
      a.i_imem_ready = 1'b1;
      tick();
      check("pend_flush", 32'(a.o_flush),    32'h1);
      check("pend_pcvld", 32'(a.o_pc_valid), 32'h0);
      check("pend_pc",    a.o_pc,            32'hC);
      check("pend_addr",  a.o_imem_addr,     32'h200);
      tick();
      check("f200_flush", 32'(a.o_flush),    32'h0);
      check("f200_pcvld", 32'(a.o_pc_valid), 32'h1);
      check("f200_pc",    a.o_pc,            32'h200);

      // 4. Trap and branch in the same cycle, coinciding with a handshake at 0x204
      a.i_trap_valid = 1'b1; a.i_branch_valid = 1'b1; a.i_branch_target = 32'h400;
      tick();
      a.i_trap_valid = 1'b0; a.i_branch_valid = 1'b0; a.i_branch_target = '0;
      check("trap_flush", 32'(a.o_flush),          32'h1);
      check("trap_pcvld", 32'(a.o_pc_valid),       32'h0);
      check("trap_req",   32'(a.o_imem_req_valid), 32'h0);
      check("trap_addr",  a.o_imem_addr,           32'h100);
      tick();
      check("post_trap_req",   32'(a.o_imem_req_valid), 32'h1);
      check("post_trap_addr",  a.o_imem_addr,           32'h100);
      check("post_trap_flush", 32'(a.o_flush),          32'h0);
      tick();
      check("f100_pc",   a.o_pc,            32'h100);
      check("f100_addr", a.o_imem_addr,     32'h104);

      // 6. Reset asserted while waiting at 0x40
      a.i_branch_valid = 1'b1; a.i_branch_target = 32'h40;
      tick();
      a.i_branch_valid = 1'b0; a.i_branch_target = '0;
      check("br40_flush", 32'(a.o_flush), 32'h1);
      check("br40_addr",  a.o_imem_addr,  32'h40);
      a.i_imem_ready = 1'b0;
      tick();
      check("w40_req", 32'(a.o_imem_req_valid), 32'h1);
      reset_n = 1'b0;
      #1;
      check("arst_req",   32'(a.o_imem_req_valid), 32'h0);
      check("arst_addr",  a.o_imem_addr,           32'h0);
      check("arst_pc",    a.o_pc,                  32'h0);
      a.i_imem_ready = 1'b1;
      @(negedge clk); reset_n = 1'b1;
      tick();
      check("rb_req",   32'(a.o_imem_req_valid), 32'h1);
      check("rb_addr",  a.o_imem_addr,           32'h0);
      check("rb_flush", 32'(a.o_flush),          32'h0);
      check("rb_pcvld", 32'(a.o_pc_valid),       32'h0);
      tick();
      check("rb_f0_pc",   a.o_pc,            32'h0);
      check("rb_f0_vld",  32'(a.o_pc_valid), 32'h1);
      check("rb_f0_addr", a.o_imem_addr,     32'h4);

      // Pending trap is not overwritten by a later branch
      a.i_imem_ready = 1'b0;
      tick();
      a.i_trap_valid = 1'b1;
      tick();
      a.i_trap_valid = 1'b0; a.i_branch_valid = 1'b1; a.i_branch_target = 32'h80;
      tick();
      a.i_branch_valid = 1'b0; a.i_branch_target = '0;
      check("pt_addr_hold", a.o_imem_addr, 32'h4);
      a.i_imem_ready = 1'b1;
      tick();
      check("pt_flush", 32'(a.o_flush),          32'h1);
      check("pt_pcvld", 32'(a.o_pc_valid),       32'h0);
      check("pt_req",   32'(a.o_imem_req_valid), 32'h0);
      check("pt_addr",  a.o_imem_addr,           32'h100);
      check("pt_pc",    a.o_pc,                  32'h0);

      // 5. Reset vector near the top of the address space wraps to zero
      @(negedge clk); rst_b_n = 1'b1;
      tick();
      check("wr_addr0", b.o_imem_addr, 32'hFFFF_FFF8);
      tick();
      check("wr_pc0",   b.o_pc,        32'hFFFF_FFF8);
      check("wr_addr1", b.o_imem_addr, 32'hFFFF_FFFC);
      tick();
      check("wr_pc1",   b.o_pc,        32'hFFFF_FFFC);
      check("wr_addr2", b.o_imem_addr, 32'h0000_0000);
      tick();
      check("wr_pc2",   b.o_pc,        32'h0000_0000);
      check("wr_vld2",  32'(b.o_pc_valid), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Fetch-side controller that owns the program counter register and selects its next value each cycle.
- Sources, in priority order: trap vector, branch redirect, hold (stall / memory backpressure), sequential increment.
- Drives a valid/ready fetch request to instruction memory and reports the address of each accepted fetch to decode.
- Sits between the execute/trap logic and the instruction memory port.

Parameters:
DATA_WIDTH_P, 32, address/PC width in bits
RESET_VECTOR_P, 0, first fetch address after reset
TRAP_VECTOR_P, 32'h0000_0100, fetch address on trap entry
INSTR_BYTES_P, 4, sequential increment; power of two, at least 2

Ports:
clk  input  1  clock, rising-edge
reset_n  input  1  asynchronous active-low reset
i_stall  input  1  decode back-pressure; no new fetch is issued while high
i_branch_valid  input  1  one-cycle redirect pulse from execute
i_branch_target  input  DATA_WIDTH_P  redirect address
i_trap_valid  input  1  one-cycle trap pulse; overrides branch
i_imem_ready  input  1  instruction memory accepts the request
o_imem_req_valid  output  1  fetch request valid
o_imem_addr  output  DATA_WIDTH_P  fetch address
o_pc_valid  output  1  one-cycle pulse: fetch at o_pc accepted, not squashed
o_pc  output  DATA_WIDTH_P  address of last accepted fetch
o_flush  output  1  one-cycle pulse: accepted fetch squashed by redirect/trap

Behaviour:
Reset (asynchronous assert, synchronous deassert):
- State BOOT; o_imem_req_valid=0; o_imem_addr=RESET_VECTOR_P; o_pc=0; o_pc_valid=0; o_flush=0.
- Redirect-pending flag and registered target cleared.

States:
- BOOT: one cycle after reset release, then ISSUE. Low address bits are not masked in BOOT.
- ISSUE: o_imem_req_valid = !i_stall.
  - Handshake (valid && ready) -> o_pc <= o_imem_addr; o_pc_valid pulses next cycle; o_imem_addr <= next address; stay in ISSUE.
  - valid && !ready -> WAIT.
- WAIT: o_imem_req_valid=1; o_imem_addr held stable; i_stall ignored (request already committed).
  - On ready -> ISSUE, with the same updates as a handshake in ISSUE.
- TRAP: one cycle after i_trap_valid; o_imem_req_valid=0; o_imem_addr=TRAP_VECTOR_P; then ISSUE.

Next-address selection, evaluated every cycle:
- 1. i_trap_valid -> TRAP_VECTOR_P; state -> TRAP, unless in WAIT (see pending).
- 2. i_branch_valid -> i_branch_target with low log2(INSTR_BYTES_P) bits forced to 0.
- 3. Handshake this cycle -> o_imem_addr + INSTR_BYTES_P, modulo 2^DATA_WIDTH_P (all-ones region wraps to 0, no flag).
- 4. Otherwise hold.

Redirect during WAIT:
- Address must stay stable, so the target is captured into a pending register.
- Trap overwrites a pending branch; a branch never overwrites a pending trap.
- On completion of the outstanding handshake: o_flush pulses instead of o_pc_valid; o_pc is not updated; o_imem_addr <= pending target; pending cleared; state -> TRAP if the pending redirect was a trap, else ISSUE.

Redirect coinciding with a handshake in ISSUE:
- The fetched instruction is squashed: o_flush=1, o_pc_valid=0 next cycle; the redirect address is used.

Other rules:
- o_pc_valid and o_flush are mutually exclusive and never high for two consecutive cycles from the same fetch.
- Reset asserted mid-WAIT: request drops immediately (asynchronous); the memory side tolerates abandonment.
- All outputs are registered except o_imem_req_valid in ISSUE, which is gated combinationally by i_stall.

Decomposition:
- Shared package `pc_seq_pkg`: state enum (BOOT, ISSUE, WAIT, TRAP); localparam for the alignment shift, log2(INSTR_BYTES_P).
- One natural sub-module, `pc_next_mux`: combinational priority select plus alignment/increment.
- FSM and registers stay in pc_sequencer.

Test Plan:
1. Reset release, ready tied 1, no stall -> BOOT 1 cycle; fetches at 0x0, 0x4, 0x8; o_pc_valid pulses with o_pc=0x0, 0x4, 0x8 on consecutive cycles.
2. i_stall high 3 cycles after fetch 0x8 -> o_imem_req_valid=0 for 3 cycles; o_imem_addr holds 0xC; resumes at 0xC.
3. ready low 4 cycles at 0x10; branch to 0x203 in cycle 2 -> address stays 0x10 until ready; then o_flush=1, no o_pc_valid; next request at 0x200.
4. Trap and branch (0x400) pulsed in the same cycle during ISSUE -> TRAP state one cycle; next request at 0x100; branch ignored.
5. RESET_VECTOR_P=0xFFFF_FFF8, ready=1 -> fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
6. reset_n asserted mid-WAIT at 0x40 -> o_imem_req_valid drops the same cycle; after release, fetch restarts at RESET_VECTOR_P with no o_flush or o_pc_valid pulse.
